// File: rtl/game_pkg.sv
// Shared game definitions: gamemode encoding, screen bounds, obstacle coordinate types.
package game_pkg;

  typedef enum logic [1:0] {
    GM_INIT  = 2'b00,
    GM_RUN   = 2'b01,
    GM_PAUSE = 2'b10,
    GM_END   = 2'b11
  } gamemode_t;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned UPPER_BOUND = 20;
  localparam int unsigned LOWER_BOUND = 460;
  localparam int unsigned COORD_W     = 11;

  typedef logic [9:0]         x_t;
  typedef logic [8:0]         y_t;
  typedef logic [COORD_W-1:0] coord_t;

  // One obstacle slot: r is the exclusive right edge in scroll space (may exceed the screen).
  typedef struct packed {
    logic   valid;
    coord_t r;
    y_t     up;
    y_t     down;
  } slot_t;

  // Clip a scroll-space x coordinate onto the visible screen.
  function automatic x_t clip_x(input coord_t v);
    coord_t c;
    c = (v > coord_t'(SCREEN_W)) ? coord_t'(SCREEN_W) : v;
    return x_t'(c);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), reloaded with SEED on reset.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [15:0] state
);

  // Shift in the tap parity every enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (enable) begin
      state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
    end
  end

endmodule

// File: rtl/obstacle_manager.sv
// Spawns, scrolls and retires up to N_OBS obstacles once per frame; drives the pixel-stage bound buses.
module obstacle_manager
  import game_pkg::*;
#(
  parameter int unsigned N_OBS          = 10,
  parameter int unsigned OBS_W          = 40,
  parameter int unsigned MIN_H          = 60,
  parameter int unsigned SPAWN_INTERVAL = 90,
  parameter int unsigned SPEED_INIT     = 2,
  parameter int unsigned SPEED_MAX      = 8,
  parameter int unsigned SPEED_UP_TICKS = 600,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic [1:0]            gamemode,
  output logic [N_OBS-1:0][9:0] obstacle_x_game_left,
  output logic [N_OBS-1:0][9:0] obstacle_x_game_right,
  output logic [N_OBS-1:0][8:0] obstacle_y_game_up,
  output logic [N_OBS-1:0][8:0] obstacle_y_game_down,
  output logic [15:0]           score,
  output logic [3:0]            speed
);

  localparam int unsigned SC_W  = $clog2(SPAWN_INTERVAL + 1);
  localparam int unsigned SU_W  = (SPEED_UP_TICKS == 0) ? 1 : $clog2(SPEED_UP_TICKS + 1);
  localparam int unsigned CNT_W = $clog2(N_OBS + 1);

  gamemode_t          mode;
  logic               step;
  logic [15:0]        lfsr_state;
  logic               lfsr_unused;
  slot_t              slot_q [N_OBS];
  slot_t              slot_d [N_OBS];
  slot_t              spawn_val;
  y_t                 spawn_h;
  logic [N_OBS-1:0]   retire;
  logic [N_OBS-1:0]   free;
  logic [N_OBS-1:0]   spawn_sel;
  logic               spawn_hit;
  logic [SC_W-1:0]    spawn_cnt_q, spawn_cnt_d;
  logic [SU_W-1:0]    speed_cnt_q, speed_cnt_d;
  logic [3:0]         speed_d;
  logic [15:0]        score_d;
  logic [16:0]        score_sum;
  logic [CNT_W-1:0]   retire_cnt;

  // Lowest-index set bit as a one-hot mask.
  function automatic logic [N_OBS-1:0] first_one(input logic [N_OBS-1:0] v);
    logic [N_OBS-1:0] oh;
    logic             seen;
    oh   = '0;
    seen = 1'b0;
    for (int i = 0; i < N_OBS; i++) begin
      if (v[i] && !seen) begin
        oh[i] = 1'b1;
        seen  = 1'b1;
      end
    end
    return oh;
  endfunction

  // Left edge: right edge minus width, floored at 0 and clipped to the screen.
  function automatic x_t left_of(input coord_t r);
    coord_t d;
    d = (r < coord_t'(OBS_W)) ? '0 : r - coord_t'(OBS_W);
    return clip_x(d);
  endfunction

  assign mode        = gamemode_t'(gamemode);
  assign step        = (mode == GM_RUN) && frame_tick;
  assign lfsr_unused = ^lfsr_state[15:8];

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .enable (1'b1),
    .state  (lfsr_state)
  );

  // A slot can take a spawn if it is empty now or empties on this tick.
  for (genvar g = 0; g < N_OBS; g++) begin : g_slot
    assign retire[g] = slot_q[g].valid && (slot_q[g].r <= coord_t'(speed));
    assign free[g]   = !slot_q[g].valid || retire[g];
  end

  assign spawn_sel = spawn_hit ? first_one(free) : '0;
  assign spawn_h   = y_t'(MIN_H) + y_t'(lfsr_state[6:0]);

  // New obstacle: enters just off the right edge, anchored top or bottom by lfsr[7].
  always_comb begin
    spawn_val       = '0;
    spawn_val.valid = 1'b1;
    spawn_val.r     = coord_t'(SCREEN_W + OBS_W);
    if (lfsr_state[7]) begin
      spawn_val.up   = y_t'(LOWER_BOUND) - spawn_h;
      spawn_val.down = y_t'(LOWER_BOUND);
    end else begin
      spawn_val.up   = y_t'(UPPER_BOUND);
      spawn_val.down = y_t'(UPPER_BOUND) + spawn_h;
    end
  end

  // Spawn interval and speed-up counters.
  always_comb begin
    spawn_cnt_d = spawn_cnt_q;
    spawn_hit   = 1'b0;
    speed_cnt_d = speed_cnt_q;
    speed_d     = speed;
    if (mode == GM_INIT) begin
      spawn_cnt_d = '0;
      speed_cnt_d = '0;
      speed_d     = 4'(SPEED_INIT);
    end else if (step) begin
      if (spawn_cnt_q + SC_W'(1) == SC_W'(SPAWN_INTERVAL)) begin
        spawn_cnt_d = '0;
        spawn_hit   = 1'b1;
      end else begin
        spawn_cnt_d = spawn_cnt_q + SC_W'(1);
      end
      if (SPEED_UP_TICKS != 0) begin
        if (speed_cnt_q + SU_W'(1) == SU_W'(SPEED_UP_TICKS)) begin
          speed_cnt_d = '0;
          if (speed < 4'(SPEED_MAX)) begin
            speed_d = speed + 4'd1;
          end
        end else begin
          speed_cnt_d = speed_cnt_q + SU_W'(1);
        end
      end
    end
  end

  // Score: add every retirement of this tick, saturating at all-ones.
  always_comb begin
    retire_cnt = '0;
    for (int i = 0; i < N_OBS; i++) begin
      retire_cnt = retire_cnt + CNT_W'(retire[i]);
    end
    score_sum = {1'b0, score} + 17'(retire_cnt);
    score_d   = score;
    if (mode == GM_INIT) begin
      score_d = '0;
    end else if (step) begin
      score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  // Per-slot next state: spawn wins over retire, otherwise scroll left by speed.
  always_comb begin
    for (int i = 0; i < N_OBS; i++) begin
      slot_d[i] = slot_q[i];
      if (mode == GM_INIT) begin
        slot_d[i] = '0;
      end else if (step) begin
        if (spawn_sel[i]) begin
          slot_d[i] = spawn_val;
        end else if (retire[i]) begin
          slot_d[i] = '0;
        end else if (slot_q[i].valid) begin
          slot_d[i].r = slot_q[i].r - coord_t'(speed);
        end
      end
    end
  end

  // Slot state plus output buses registered from the next slot state, so they always match.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_OBS; i++) begin
        slot_q[i] <= '0;
      end
      obstacle_x_game_left  <= '0;
      obstacle_x_game_right <= '0;
      obstacle_y_game_up    <= '0;
      obstacle_y_game_down  <= '0;
    end else begin
      for (int i = 0; i < N_OBS; i++) begin
        slot_q[i]                <= slot_d[i];
        obstacle_x_game_left[i]  <= slot_d[i].valid ? left_of(slot_d[i].r) : '0;
        obstacle_x_game_right[i] <= slot_d[i].valid ? clip_x(slot_d[i].r) : '0;
        obstacle_y_game_up[i]    <= slot_d[i].valid ? slot_d[i].up : '0;
        obstacle_y_game_down[i]  <= slot_d[i].valid ? slot_d[i].down : '0;
      end
    end
  end

  // Counters, speed and score registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      spawn_cnt_q <= '0;
      speed_cnt_q <= '0;
      speed       <= 4'(SPEED_INIT);
      score       <= '0;
    end else begin
      spawn_cnt_q <= spawn_cnt_d;
      speed_cnt_q <= speed_cnt_d;
      speed       <= speed_d;
      score       <= score_d;
    end
  end

endmodule

// File: tb/tb_obstacle_manager.sv
// Bench for obstacle_manager: three parameterisations driven in lockstep against a behavioural model.
module tb_obstacle_manager;

  localparam int N = 10;
  localparam int P_SI    [3] = '{90, 1, 90};
  localparam int P_SINIT [3] = '{2, 1, 2};
  localparam int P_SUT   [3] = '{0, 0, 600};
  localparam logic [1:0] M_INIT = 2'b00, M_RUN = 2'b01, M_PAUSE = 2'b10, M_END = 2'b11;

  logic clk = 1'b0;
  logic rst, frame_tick;
  logic [1:0] gamemode;

  logic [N-1:0][9:0] xl [3];
  logic [N-1:0][9:0] xr [3];
  logic [N-1:0][8:0] yu [3];
  logic [N-1:0][8:0] yd [3];
  logic [15:0] sc [3];
  logic [3:0]  sp [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  obstacle_manager #(.SPEED_UP_TICKS(0)) dut0 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .gamemode(gamemode),
    .obstacle_x_game_left(xl[0]), .obstacle_x_game_right(xr[0]),
    .obstacle_y_game_up(yu[0]), .obstacle_y_game_down(yd[0]),
    .score(sc[0]), .speed(sp[0]));

  obstacle_manager #(.SPAWN_INTERVAL(1), .SPEED_INIT(1), .SPEED_UP_TICKS(0)) dut1 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .gamemode(gamemode),
    .obstacle_x_game_left(xl[1]), .obstacle_x_game_right(xr[1]),
    .obstacle_y_game_up(yu[1]), .obstacle_y_game_down(yd[1]),
    .score(sc[1]), .speed(sp[1]));

  obstacle_manager dut2 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .gamemode(gamemode),
    .obstacle_x_game_left(xl[2]), .obstacle_x_game_right(xr[2]),
    .obstacle_y_game_up(yu[2]), .obstacle_y_game_down(yd[2]),
    .score(sc[2]), .speed(sp[2]));

  // ---------------- behavioural model ----------------
  bit          mv [3][N];
  int          mr [3][N];
  int          mu [3][N];
  int          md [3][N];
  int          mscnt [3];
  int          mucnt [3];
  int          mspd [3];
  int          mscore [3];
  logic [15:0] mlfsr;

  task automatic model_clear(input int k);
    for (int i = 0; i < N; i++) begin
      mv[k][i] = 1'b0; mr[k][i] = 0; mu[k][i] = 0; md[k][i] = 0;
    end
    mscnt[k] = 0; mucnt[k] = 0; mspd[k] = P_SINIT[k]; mscore[k] = 0;
  endtask

  task automatic model_tick(input int k);
    int freeidx, ret, h;
    freeidx = -1;
    ret = 0;
    for (int i = 0; i < N; i++) begin
      if (mv[k][i] && mr[k][i] <= mspd[k]) begin
        mv[k][i] = 1'b0; mr[k][i] = 0; mu[k][i] = 0; md[k][i] = 0;
        ret++;
        if (freeidx < 0) freeidx = i;
      end else if (mv[k][i]) begin
        mr[k][i] -= mspd[k];
      end else if (freeidx < 0) begin
        freeidx = i;
      end
    end
    mscore[k] = (mscore[k] + ret > 65535) ? 65535 : mscore[k] + ret;
    mscnt[k]++;
    if (mscnt[k] == P_SI[k]) begin
      mscnt[k] = 0;
      if (freeidx >= 0) begin
        h = 60 + int'(mlfsr[6:0]);
        mv[k][freeidx] = 1'b1;
        mr[k][freeidx] = 680;
        if (mlfsr[7]) begin mu[k][freeidx] = 460 - h; md[k][freeidx] = 460; end
        else          begin mu[k][freeidx] = 20;      md[k][freeidx] = 20 + h; end
      end
    end
    if (P_SUT[k] != 0) begin
      mucnt[k]++;
      if (mucnt[k] == P_SUT[k]) begin
        mucnt[k] = 0;
        if (mspd[k] < 8) mspd[k]++;
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) model_clear(k);
      mlfsr = 16'hACE1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (gamemode == M_INIT) model_clear(k);
        else if (gamemode == M_RUN && frame_tick) model_tick(k);
      end
      mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
    end
  end

  function automatic logic [N-1:0][9:0] e_left(input int k);
    logic [N-1:0][9:0] e;
    int v;
    for (int i = 0; i < N; i++) begin
      v = mr[k][i] - 40;
      if (v < 0) v = 0;
      if (v > 640) v = 640;
      e[i] = mv[k][i] ? 10'(v) : 10'd0;
    end
    return e;
  endfunction

  function automatic logic [N-1:0][9:0] e_right(input int k);
    logic [N-1:0][9:0] e;
    for (int i = 0; i < N; i++)
      e[i] = mv[k][i] ? 10'((mr[k][i] > 640) ? 640 : mr[k][i]) : 10'd0;
    return e;
  endfunction

  function automatic logic [N-1:0][8:0] e_up(input int k);
    logic [N-1:0][8:0] e;
    for (int i = 0; i < N; i++) e[i] = mv[k][i] ? 9'(mu[k][i]) : 9'd0;
    return e;
  endfunction

  function automatic logic [N-1:0][8:0] e_down(input int k);
    logic [N-1:0][8:0] e;
    for (int i = 0; i < N; i++) e[i] = mv[k][i] ? 9'(md[k][i]) : 9'd0;
    return e;
  endfunction

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic r, input logic t, input logic [1:0] m);
    rst = r; frame_tick = t; gamemode = m;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cyc(1'b1, 1'b0, M_INIT);
    cyc(1'b1, 1'b0, M_INIT);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({xl[k], xr[k], yu[k], yd[k]} !== '0) begin
        errors++; $display("FAIL reset_buses dut%0d: got %h required 0", k, {xl[k], xr[k]});
      end
      checks++;
      if (sc[k] !== 16'd0) begin errors++; $display("FAIL reset_score dut%0d: got %0d required 0", k, sc[k]); end
      checks++;
      if (sp[k] !== 4'(P_SINIT[k])) begin
        errors++; $display("FAIL reset_speed dut%0d: got %0d required %0d", k, sp[k], P_SINIT[k]);
      end
    end
  endtask

  task automatic test_spawn();
    repeat (89) cyc(1'b0, 1'b1, M_RUN);
    checks++;
    if (xr[0] !== '0) begin errors++; $display("FAIL spawn_early: got %h required 0", xr[0]); end
    cyc(1'b0, 1'b1, M_RUN);
    checks++;
    if (xl[0][0] !== 10'd640 || xr[0][0] !== 10'd640) begin
      errors++; $display("FAIL spawn_x: got left=%0d right=%0d required 640/640", xl[0][0], xr[0][0]);
    end
    checks++;
    if (yu[0][0] !== 9'(mu[0][0]) || yd[0][0] !== 9'(md[0][0])) begin
      errors++; $display("FAIL spawn_y: got up=%0d down=%0d required %0d/%0d", yu[0][0], yd[0][0], mu[0][0], md[0][0]);
    end
    checks++;
    if (!(yu[0][0] === 9'd20 || yd[0][0] === 9'd460)) begin
      errors++; $display("FAIL spawn_anchor: got up=%0d down=%0d required up=20 or down=460", yu[0][0], yd[0][0]);
    end
    checks++;
    if ({xl[0][N-1:1], xr[0][N-1:1], yu[0][N-1:1], yd[0][N-1:1]} !== '0) begin
      errors++; $display("FAIL spawn_others: got %h required 0", xr[0][N-1:1]);
    end
    cyc(1'b0, 1'b1, M_RUN);
    checks++;
    if (xl[0][0] !== 10'd638 || xr[0][0] !== 10'd640) begin
      errors++; $display("FAIL scroll_first: got left=%0d right=%0d required 638/640", xl[0][0], xr[0][0]);
    end
  endtask

  task automatic test_retire();
    int n = 0;
    while (!(mv[0][0] && mr[0][0] == 2) && n < 500) begin
      cyc(1'b0, 1'b1, M_RUN);
      n++;
    end
    checks++;
    if (n >= 500) begin errors++; $display("FAIL retire_timeout: got %0d ticks required < 500", n); end
    checks++;
    if (xl[0][0] !== 10'd0 || xr[0][0] !== 10'd2 || sc[0] !== 16'd0) begin
      errors++; $display("FAIL retire_edge: got left=%0d right=%0d score=%0d required 0/2/0", xl[0][0], xr[0][0], sc[0]);
    end
    cyc(1'b0, 1'b1, M_RUN);
    checks++;
    if ({xl[0][0], xr[0][0], yu[0][0], yd[0][0]} !== '0) begin
      errors++; $display("FAIL retire_clear: got left=%0d right=%0d required all 0", xl[0][0], xr[0][0]);
    end
    checks++;
    if (sc[0] !== 16'd1) begin errors++; $display("FAIL retire_score: got %0d required 1", sc[0]); end
  endtask

  task automatic test_pause_end();
    int er;
    logic [1:0] modes [2];
    er = mr[0][1];
    modes[0] = M_PAUSE;
    modes[1] = M_END;
    for (int p = 0; p < 2; p++) begin
      repeat (50) cyc(1'b0, 1'b1, modes[p]);
      checks++;
      if (xr[0][1] !== 10'((er > 640) ? 640 : er)) begin
        errors++; $display("FAIL hold_r mode=%0d: got %0d required %0d", modes[p], xr[0][1], er);
      end
      checks++;
      if (xl[0] !== e_left(0) || xr[0] !== e_right(0) || yu[0] !== e_up(0) || yd[0] !== e_down(0)) begin
        errors++; $display("FAIL hold_buses mode=%0d: got %h required %h", modes[p], xl[0], e_left(0));
      end
      checks++;
      if (sc[0] !== 16'd1) begin errors++; $display("FAIL hold_score mode=%0d: got %0d required 1", modes[p], sc[0]); end
    end
    cyc(1'b0, 1'b1, M_RUN);
    checks++;
    if (xr[0][1] !== 10'(((er - 2) > 640) ? 640 : er - 2)) begin
      errors++; $display("FAIL resume_r: got %0d required %0d", xr[0][1], er - 2);
    end
  endtask

  task automatic test_init();
    cyc(1'b0, 1'b1, M_INIT);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({xl[k], xr[k], yu[k], yd[k]} !== '0 || sc[k] !== 16'd0 || sp[k] !== 4'(P_SINIT[k])) begin
        errors++; $display("FAIL init dut%0d: got score=%0d speed=%0d right=%h required 0/%0d/0", k, sc[k], sp[k], P_SINIT[k], xr[k]);
      end
    end
  endtask

  task automatic test_full_set();
    repeat (10) cyc(1'b0, 1'b1, M_RUN);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (xr[1][i] !== 10'd640 || xl[1][i] !== 10'(640 - (9 - i)) || yd[1][i] === 9'd0) begin
        errors++; $display("FAIL full_slot%0d: got left=%0d right=%0d required %0d/640", i, xl[1][i], xr[1][i], 640 - (9 - i));
      end
    end
    cyc(1'b0, 1'b1, M_RUN);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (xl[1][i] !== 10'(640 - (10 - i))) begin
        errors++; $display("FAIL full_drop_slot%0d: got left=%0d required %0d", i, xl[1][i], 640 - (10 - i));
      end
    end
    checks++;
    if (sc[1] !== 16'd0) begin errors++; $display("FAIL full_score: got %0d required 0", sc[1]); end
    checks++;
    if (yu[1] !== e_up(1) || yd[1] !== e_down(1)) begin
      errors++; $display("FAIL full_y: got %h required %h", yd[1], e_down(1));
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    while (!(mv[1][0] && mr[1][0] == 1) && n < 1000) begin
      cyc(1'b0, 1'b1, M_RUN);
      n++;
    end
    checks++;
    if (n >= 1000 || xr[1][0] !== 10'd1 || sc[1] !== 16'd0) begin
      errors++; $display("FAIL b2b_setup: got right=%0d score=%0d ticks=%0d required 1/0", xr[1][0], sc[1], n);
    end
    cyc(1'b0, 1'b1, M_RUN);
    checks++;
    if (xl[1][0] !== 10'd640 || xr[1][0] !== 10'd640) begin
      errors++; $display("FAIL b2b_respawn: got left=%0d right=%0d required 640/640", xl[1][0], xr[1][0]);
    end
    checks++;
    if (sc[1] !== 16'd1) begin errors++; $display("FAIL b2b_score: got %0d required 1", sc[1]); end
    checks++;
    if (xr[1] !== e_right(1) || yu[1] !== e_up(1)) begin
      errors++; $display("FAIL b2b_buses: got %h required %h", xr[1], e_right(1));
    end
  endtask

  task automatic test_rst_with_tick();
    cyc(1'b1, 1'b1, M_RUN);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({xl[k], xr[k], yu[k], yd[k]} !== '0 || sc[k] !== 16'd0 || sp[k] !== 4'(P_SINIT[k])) begin
        errors++; $display("FAIL rst_tick dut%0d: got score=%0d speed=%0d right=%h required 0/%0d/0", k, sc[k], sp[k], P_SINIT[k], xr[k]);
      end
    end
    repeat (90) cyc(1'b0, 1'b1, M_RUN);
    checks++;
    if (xl[0][0] !== 10'd640 || yu[0][0] !== 9'(mu[0][0]) || yd[0][0] !== 9'(md[0][0])) begin
      errors++; $display("FAIL rst_lfsr: got left=%0d up=%0d down=%0d required 640/%0d/%0d", xl[0][0], yu[0][0], yd[0][0], mu[0][0], md[0][0]);
    end
  endtask

  task automatic test_speed_up();
    int exp_spd;
    cyc(1'b0, 1'b0, M_INIT);
    for (int n = 1; n <= 4200; n++) begin
      cyc(1'b0, 1'b1, M_RUN);
      exp_spd = 2 + n / 600;
      if (exp_spd > 8) exp_spd = 8;
      checks++;
      if (sp[2] !== 4'(exp_spd)) begin
        errors++; $display("FAIL speed_up tick=%0d: got %0d required %0d", n, sp[2], exp_spd);
      end
    end
    checks++;
    if (sp[0] !== 4'd2) begin errors++; $display("FAIL speed_fixed: got %0d required 2", sp[0]); end
  endtask

  task automatic test_random();
    int sel;
    logic r, t;
    logic [1:0] m;
    for (int n = 0; n < 3000 && errors < 20; n++) begin
      sel = int'($urandom_range(0, 999));
      r = 1'b0;
      if (sel < 850)      m = M_RUN;
      else if (sel < 910) m = M_PAUSE;
      else if (sel < 970) m = M_END;
      else if (sel < 995) m = M_INIT;
      else begin m = M_RUN; r = 1'b1; end
      t = ($urandom_range(0, 3) != 0);
      cyc(r, t, m);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (xl[k] !== e_left(k)) begin errors++; $display("FAIL rnd_left dut%0d: got %h required %h", k, xl[k], e_left(k)); end
        checks++;
        if (xr[k] !== e_right(k)) begin errors++; $display("FAIL rnd_right dut%0d: got %h required %h", k, xr[k], e_right(k)); end
        checks++;
        if (yu[k] !== e_up(k)) begin errors++; $display("FAIL rnd_up dut%0d: got %h required %h", k, yu[k], e_up(k)); end
        checks++;
        if (yd[k] !== e_down(k)) begin errors++; $display("FAIL rnd_down dut%0d: got %h required %h", k, yd[k], e_down(k)); end
        checks++;
        if (sc[k] !== 16'(mscore[k])) begin errors++; $display("FAIL rnd_score dut%0d: got %0d required %0d", k, sc[k], mscore[k]); end
        checks++;
        if (sp[k] !== 4'(mspd[k])) begin errors++; $display("FAIL rnd_speed dut%0d: got %0d required %0d", k, sp[k], mspd[k]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    frame_tick = 1'b0;
    gamemode = M_INIT;
    test_reset();
    test_spawn();
    test_retire();
    test_pause_end();
    test_init();
    test_full_set();
    test_back_to_back();
    test_rst_with_tick();
    test_speed_up();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/obstacle_manager.md
Name: obstacle_manager

Overview:
- Generates and scrolls the in-game obstacle set: up to 10 axis-aligned rectangles in screen coordinates.
- Drives the packed obstacle bound buses consumed directly by the VGA pixel/colour stage (left/right x, up/down y per slot).
- Updates once per video frame on a frame tick from the VGA timing stage and follows the shared 2-bit gamemode encoding:
  - 00: init
  - 01: running
  - 10: paused
  - 11: ended
- Also counts retired obstacles as the score.

Parameters:
- N_OBS, 10, number of obstacle slots (fixed by the pixel stage bus width)
- SCREEN_W, 640, visible width in pixels
- UPPER_BOUND, 20, top play boundary y
- LOWER_BOUND, 460, bottom play boundary y
- OBS_W, 40, obstacle width in pixels
- MIN_H, 60, minimum obstacle height
- SPAWN_INTERVAL, 90, frame ticks between spawn attempts
- SPEED_INIT, 2, initial scroll speed in px/frame
- SPEED_MAX, 8, speed ceiling
- SPEED_UP_TICKS, 600, frames per +1 speed step; 0 disables speed-up
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_tick  in  1  one-cycle pulse per frame, issued after the last visible line
- gamemode  in  2  game state (00 init, 01 run, 10 pause, 11 ended)
- obstacle_x_game_left  out  [N_OBS-1:0][9:0]  rendered left x per slot
- obstacle_x_game_right  out  [N_OBS-1:0][9:0]  rendered right x, exclusive
- obstacle_y_game_up  out  [N_OBS-1:0][8:0]  top y, inclusive
- obstacle_y_game_down  out  [N_OBS-1:0][8:0]  bottom y, exclusive
- score  out  16  obstacles retired since last init; saturates at FFFF
- speed  out  4  current scroll speed

Behaviour:
- Clocking/reset:
  - One clock. rst is synchronous, active-high, and has priority over everything.
  - On rst: all slots invalid, spawn_cnt=0, speed_cnt=0, speed=SPEED_INIT, score=0, LFSR=LFSR_SEED.
- Per-slot state: valid bit, r (11-bit right edge, 0..SCREEN_W+OBS_W), up, down.
- Outputs are registered and combinationally derived from slot state:
  - Valid slot: left = sat0(r-OBS_W) clipped to SCREEN_W; right = min(r, SCREEN_W).
  - Invalid slot: all four fields = 0 (empty rectangle, never hit).
  - All outputs are 0 after rst.
- LFSR: 16-bit Fibonacci with taps 16,14,13,11. Advances every clock regardless of gamemode and is never cleared except by rst.
- gamemode 00 (init), applied every cycle: clear all slots, spawn_cnt, speed_cnt, score; speed=SPEED_INIT. frame_tick is ignored.
- gamemode 10/11: all state holds (the ended screen still shows final obstacles). frame_tick is ignored.
- gamemode 01 on frame_tick: one-cycle update; new values are visible the cycle after the tick.
  - 1) Retire: each valid slot with r <= speed becomes invalid and score += 1 (sum of all retirements this tick, saturating).
  - 2) Scroll: each other valid slot gets r -= speed.
  - 3) Spawn timing: spawn_cnt += 1. When it reaches SPAWN_INTERVAL, reset it to 0 and attempt a spawn.
  - 4) Spawn slot: lowest-index slot that is invalid before this tick OR retiring this tick. If no slot qualifies, the spawn is dropped silently.
  - 5) Spawned slot values:
    - r = SCREEN_W + OBS_W
    - h = MIN_H + lfsr[6:0]
    - lfsr[7]=0: top-anchored, up=UPPER_BOUND, down=UPPER_BOUND+h
    - lfsr[7]=1: bottom-anchored, up=LOWER_BOUND-h, down=LOWER_BOUND
  - 6) Speed: when SPEED_UP_TICKS != 0, speed_cnt += 1. When it reaches SPEED_UP_TICKS, reset it to 0 and set speed = min(speed+1, SPEED_MAX). The new speed applies from the next tick.
- frame_tick outside mode 01 is not queued.
- Mode change and tick in the same cycle: the mode sampled in that cycle governs.
- Width rules: all arithmetic is done 11-bit unsigned; y values always fit 9 bits (max 460).

Decomposition:
- Shared package game_pkg:
  - gamemode enum (GM_INIT, GM_RUN, GM_PAUSE, GM_END)
  - SCREEN_W, UPPER_BOUND, LOWER_BOUND
  - obstacle bound typedefs (x_t = logic[9:0], y_t = logic[8:0])
- Sub-module lfsr16: enable, seed parameter, 16-bit state out.
- Slot logic stays inline in a generate/for loop, with a priority-encoder function for free-slot selection.

Test Plan:
- Spawn: rst; gamemode=01; 90 ticks -> slot0 valid with left=640, right=640. Next tick -> left=638, right=640. Slots 1-9 remain all-zero.
- Scroll/retire (SPEED_UP_TICKS=0): keep running until slot0 has r=2 -> left=0, right=2. Next tick -> slot0 all-zero and score=1.
- Pause/end hold: gamemode=10 with 50 ticks -> all outputs and score unchanged. gamemode=11 -> same. Back to 01 -> scrolling resumes from the held r.
- Full set (SPAWN_INTERVAL=1, speed 1): run 10 ticks -> slots 0-9 valid. Tick 11 -> no slot changes other than scroll, and score=0.
- Same-tick retire+spawn: arrange slot0 retiring on the spawn tick while slots 1-9 are valid -> slot0 respawns with r=680 and score increments by 1.
- Init/reset mid-game: gamemode=00 for one cycle -> all buses 0, speed=2, score=0. rst asserted together with frame_tick -> LFSR reloads 16'hACE1 and no spawn occurs.
